// File: rtl/sw_pkg.sv
// Shared definitions for the affine-gap Smith-Waterman PE: default penalties,
// the score type and the saturating adder used by every score path.
package sw_pkg;

    // Default score width; modules override it through their SCORE_W parameter.
    localparam int unsigned DefScoreW = 10;

    // Penalty register values after reset.
    localparam int DefMatch    = 2;
    localparam int DefMismatch = -2;
    localparam int DefGapOpen  = -2;
    localparam int DefGapExt   = -1;

    typedef logic signed [DefScoreW-1:0] score_t;

    // Wide carrier for saturating arithmetic; score widths up to 31 bits fit.
    localparam int unsigned SatW = 32;
    typedef logic signed [SatW-1:0] wide_t;

    // Sign-extended a + b clamped to the signed range of a w-bit score.
    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo  = -hi - 32'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sw_max3_sat.sv
// Combinational signed max of three scores with a floor at zero (local alignment).
module sw_max3_sat #(
    parameter int unsigned W = 10
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] c,
    output logic signed [W-1:0] y
);

    // Running maximum starting from the zero floor.
    always_comb begin
        y = '0;
        if (a > y) y = a;
        if (b > y) y = b;
        if (c > y) y = c;
    end

endmodule

// File: rtl/sw_affine_pe_cfg.sv
// Smith-Waterman systolic PE with affine gaps, run-time penalties, saturating
// arithmetic, per-PE best-score tracking and a daisy-chained readout register.
module sw_affine_pe_cfg
    import sw_pkg::*;
#(
    parameter  int unsigned SCORE_W = 10,
    parameter  int unsigned SYM_W   = 2,
    parameter  int unsigned POS_W   = 16,
    localparam int unsigned RES_W   = SCORE_W + POS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_load,
    input  logic signed [SCORE_W-1:0] cfg_match,
    input  logic signed [SCORE_W-1:0] cfg_mismatch,
    input  logic signed [SCORE_W-1:0] cfg_gap_open,
    input  logic signed [SCORE_W-1:0] cfg_gap_ext,
    input  logic signed [SCORE_W-1:0] V_in,
    input  logic signed [SCORE_W-1:0] F_in,
    input  logic        [SYM_W-1:0]   T_in,
    input  logic        [SYM_W-1:0]   S_in,
    input  logic                      store_S,
    input  logic                      init_in,
    input  logic                      rd_load,
    input  logic                      rd_shift,
    input  logic        [RES_W-1:0]   res_in,
    output logic signed [SCORE_W-1:0] V_out,
    output logic signed [SCORE_W-1:0] F_out,
    output logic        [SYM_W-1:0]   T_out,
    output logic                      init_out,
    output logic                      done_out,
    output logic        [RES_W-1:0]   res_out
);

    typedef logic signed [SCORE_W-1:0] sc_t;

    // Saturating add at this PE's score width.
    function automatic sc_t add_sat(input sc_t a, input sc_t b);
        wide_t s;
        s = sat_add(wide_t'(a), wide_t'(b), SCORE_W);
        return sc_t'(s[SCORE_W-1:0]);
    endfunction

    sc_t              pen_match_q, pen_mismatch_q, pen_gap_open_q, pen_gap_ext_q;
    sc_t              v_q, e_q, f_q, vdiag_q, best_q;
    logic [SYM_W-1:0] t_q, s_q;
    logic             init_q, done_q;
    logic [POS_W-1:0] col_q, bcol_q;
    logic [RES_W-1:0] res_q;

    logic             start;
    sc_t              sub_score, e_open, e_ext, f_open, f_ext;
    sc_t              new_e, new_f, diag, v_new, best_base;
    logic [POS_W-1:0] col_cur, col_next;
    logic             improve;

    // Cell recurrence, column numbering and best-score comparison.
    always_comb begin
        start     = init_in & ~init_q;
        sub_score = (s_q == T_in) ? pen_match_q : pen_mismatch_q;
        e_open    = add_sat(v_q, pen_gap_open_q);
        e_ext     = add_sat(e_q, pen_gap_ext_q);
        f_open    = add_sat(V_in, pen_gap_open_q);
        f_ext     = add_sat(F_in, pen_gap_ext_q);
        new_e     = (e_open > e_ext) ? e_open : e_ext;
        new_f     = (f_open > f_ext) ? f_open : f_ext;
        diag      = add_sat(vdiag_q, sub_score);
        // A new run restarts numbering at column 0 and forgets the old best.
        col_cur   = start ? '0 : col_q;
        col_next  = (col_cur == '1) ? col_cur : col_cur + POS_W'(1);
        best_base = start ? '0 : best_q;
        improve   = v_new > best_base;
    end

    sw_max3_sat #(
        .W(SCORE_W)
    ) u_vmax (
        .a(new_e),
        .b(new_f),
        .c(diag),
        .y(v_new)
    );

    // Run-time penalty registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pen_match_q    <= SCORE_W'(DefMatch);
            pen_mismatch_q <= SCORE_W'(DefMismatch);
            pen_gap_open_q <= SCORE_W'(DefGapOpen);
            pen_gap_ext_q  <= SCORE_W'(DefGapExt);
        end else if (cfg_load) begin
            pen_match_q    <= cfg_match;
            pen_mismatch_q <= cfg_mismatch;
            pen_gap_open_q <= cfg_gap_open;
            pen_gap_ext_q  <= cfg_gap_ext;
        end
    end

    // Systolic pass-through, query symbol and end-of-run pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q     <= '0;
            s_q     <= '0;
            vdiag_q <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            t_q     <= T_in;
            vdiag_q <= V_in;
            init_q  <= init_in;
            done_q  <= init_q & ~init_in;
            if (store_S) s_q <= S_in;
        end
    end

    // Score state and best-score tracking; scores clear while inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            e_q    <= '0;
            f_q    <= '0;
            col_q  <= '0;
            best_q <= '0;
            bcol_q <= '0;
        end else if (init_in) begin
            v_q   <= v_new;
            e_q   <= new_e;
            f_q   <= new_f;
            col_q <= col_next;
            if (improve) begin
                best_q <= v_new;
                bcol_q <= col_cur;
            end else if (start) begin
                best_q <= '0;
                bcol_q <= '0;
            end
        end else begin
            v_q <= '0;
            e_q <= '0;
            f_q <= '0;
        end
    end

    // Readout register: load own result, else shift from the downstream PE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (rd_load) begin
            res_q <= {best_q, bcol_q};
        end else if (rd_shift) begin
            res_q <= res_in;
        end
    end

    assign V_out    = v_q;
    assign F_out    = f_q;
    assign T_out    = t_q;
    assign init_out = init_q;
    assign done_out = done_q;
    assign res_out  = res_q;

endmodule

// File: tb/tb_sw_affine_pe_cfg.sv
// Three-PE chain bench: behavioural array model checked every cycle, plus
// hand-computed expectations on PE0.
module tb_sw_affine_pe_cfg;

    localparam int N  = 3;
    localparam int SW = 10;
    localparam int YW = 2;
    localparam int PW = 16;
    localparam int RW = SW + PW;
    localparam int SMAX = 511;
    localparam int SMIN = -512;
    localparam int CMAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cfg_load;
    logic signed [SW-1:0] cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_ext;
    logic signed [SW-1:0] v_host, f_host;
    logic [YW-1:0] t_host;
    logic init_host;
    logic [YW-1:0] s_in [N];
    logic store_s [N];
    logic rd_load, rd_shift;

    logic signed [SW-1:0] v_o [N];
    logic signed [SW-1:0] f_o [N];
    logic [YW-1:0] t_o [N];
    logic init_o [N];
    logic done_o [N];
    logic [RW-1:0] res_o [N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pe
        logic signed [SW-1:0] vi, fi;
        logic [YW-1:0] ti;
        logic ii;
        logic [RW-1:0] ri;
        if (g == 0) begin : g_head
            assign vi = v_host;
            assign fi = f_host;
            assign ti = t_host;
            assign ii = init_host;
        end else begin : g_link
            assign vi = v_o[g-1];
            assign fi = f_o[g-1];
            assign ti = t_o[g-1];
            assign ii = init_o[g-1];
        end
        if (g == N - 1) begin : g_tail
            assign ri = '0;
        end else begin : g_mid
            assign ri = res_o[g+1];
        end
        sw_affine_pe_cfg #(
            .SCORE_W(SW),
            .SYM_W(YW),
            .POS_W(PW)
        ) u_pe (
            .clk(clk),
            .rst(rst),
            .cfg_load(cfg_load),
            .cfg_match(cfg_match),
            .cfg_mismatch(cfg_mismatch),
            .cfg_gap_open(cfg_gap_open),
            .cfg_gap_ext(cfg_gap_ext),
            .V_in(vi),
            .F_in(fi),
            .T_in(ti),
            .S_in(s_in[g]),
            .store_S(store_s[g]),
            .init_in(ii),
            .rd_load(rd_load),
            .rd_shift(rd_shift),
            .res_in(ri),
            .V_out(v_o[g]),
            .F_out(f_o[g]),
            .T_out(t_o[g]),
            .init_out(init_o[g]),
            .done_out(done_o[g]),
            .res_out(res_o[g])
        );
    end

    // ---------------- behavioural model ----------------
    int m_v[N], m_e[N], m_f[N], m_vd[N], m_t[N], m_s[N];
    int m_init[N], m_done[N], m_col[N], m_best[N], m_bcol[N], m_res[N];
    int p_match, p_mis, p_go, p_ge;
    bit model_on = 1'b0;

    function automatic int clamp(int x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            m_v[p] = 0; m_e[p] = 0; m_f[p] = 0; m_vd[p] = 0; m_t[p] = 0; m_s[p] = 0;
            m_init[p] = 0; m_done[p] = 0; m_col[p] = 0; m_best[p] = 0; m_bcol[p] = 0;
            m_res[p] = 0;
        end
        p_match = 2; p_mis = -2; p_go = -2; p_ge = -1;
    endtask

    task automatic model_step();
        // Readout: each PE takes the pre-edge value of its right neighbour.
        for (int p = 0; p < N; p++) begin
            if (rd_load) m_res[p] = m_best[p] * 65536 + m_bcol[p];
            else if (rd_shift) m_res[p] = (p == N - 1) ? 0 : m_res[p+1];
        end
        // Right to left so every PE still sees its left neighbour's pre-edge state.
        for (int p = N - 1; p >= 0; p--) begin
            int vi, fi, ti, ii, h, he, hf, hd, col;
            if (p == 0) begin
                vi = v_host; fi = f_host; ti = t_host; ii = init_host;
            end else begin
                vi = m_v[p-1]; fi = m_f[p-1]; ti = m_t[p-1]; ii = m_init[p-1];
            end
            if (ii != 0) begin
                col = (m_init[p] == 0) ? 0 : m_col[p];
                if (m_init[p] == 0) begin
                    m_best[p] = 0;
                    m_bcol[p] = 0;
                end
                he = imax(clamp(m_v[p] + p_go), clamp(m_e[p] + p_ge));
                hf = imax(clamp(vi + p_go), clamp(fi + p_ge));
                hd = clamp(m_vd[p] + ((m_s[p] == ti) ? p_match : p_mis));
                h  = imax(imax(0, he), imax(hf, hd));
                if (h > m_best[p]) begin
                    m_best[p] = h;
                    m_bcol[p] = col;
                end
                m_col[p] = (col < CMAX) ? col + 1 : col;
                m_v[p] = h; m_e[p] = he; m_f[p] = hf;
            end else begin
                m_v[p] = 0; m_e[p] = 0; m_f[p] = 0;
            end
            m_done[p] = (m_init[p] != 0 && ii == 0) ? 1 : 0;
            m_init[p] = ii;
            m_vd[p] = vi;
            m_t[p] = ti;
            if (store_s[p]) m_s[p] = s_in[p];
        end
        if (cfg_load) begin
            p_match = cfg_match; p_mis = cfg_mismatch; p_go = cfg_gap_open; p_ge = cfg_gap_ext;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
                model_on = 1'b1;
            end else if (model_on) begin
                model_step();
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every PE against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                for (int p = 0; p < N; p++) begin
                    chk($sformatf("V_out[%0d]", p), v_o[p], m_v[p]);
                    chk($sformatf("F_out[%0d]", p), f_o[p], m_f[p]);
                    chk($sformatf("T_out[%0d]", p), t_o[p], m_t[p]);
                    chk($sformatf("init_out[%0d]", p), init_o[p], m_init[p]);
                    chk($sformatf("done_out[%0d]", p), done_o[p], m_done[p]);
                    chk($sformatf("res_out[%0d]", p), res_o[p], m_res[p]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int init, input int t, input int v, input int f);
        init_host = init[0];
        t_host = t[YW-1:0];
        v_host = v[SW-1:0];
        f_host = f[SW-1:0];
    endtask

    task automatic set_cfg(input int m, input int mm, input int go, input int ge);
        cfg_load = 1'b1;
        cfg_match = m[SW-1:0];
        cfg_mismatch = mm[SW-1:0];
        cfg_gap_open = go[SW-1:0];
        cfg_gap_ext = ge[SW-1:0];
    endtask

    initial begin
        cfg_load = 1'b0;
        cfg_match = '0; cfg_mismatch = '0; cfg_gap_open = '0; cfg_gap_ext = '0;
        rd_load = 1'b0; rd_shift = 1'b0;
        drive(0, 0, 0, 0);
        for (int p = 0; p < N; p++) begin
            s_in[p] = '0;
            store_s[p] = 1'b0;
        end
        #1 rst = 1'b1;
        #20;
        chk("reset V_out0", v_o[0], 0);
        chk("reset res_out0", res_o[0], 0);
        cyc();
        rst = 1'b0;

        // Query symbols 0,1,2 across the chain.
        for (int p = 0; p < N; p++) begin
            s_in[p] = YW'(p);
            store_s[p] = 1'b1;
        end
        cyc();
        for (int p = 0; p < N; p++) store_s[p] = 1'b0;
        cyc();

        // Single matching cell with default penalties.
        drive(1, 0, 0, 0);
        cyc();
        chk("t1 V_out0", v_o[0], 2);
        chk("t1 F_out0", f_o[0], -1);
        drive(0, 0, 0, 0);
        cyc();
        chk("t1 done pulse", done_o[0], 1);
        cyc();
        chk("t1 done low", done_o[0], 0);
        rd_load = 1'b1;
        cyc();
        rd_load = 1'b0;
        chk("t1 res_out0", res_o[0], 2 * 65536 + 0);

        // Mismatch never goes negative.
        drive(1, 1, 0, 0);
        cyc();
        chk("t2 V_out0", v_o[0], 0);
        drive(0, 0, 0, 0);
        cyc();
        cyc();

        // Saturation at both ends of the score range.
        drive(0, 0, 510, 0);
        cyc();
        drive(1, 0, 0, -512);
        cyc();
        chk("t3 V sat high", v_o[0], 511);
        chk("t3 F_out0", f_o[0], -2);
        drive(1, 1, -512, -512);
        cyc();
        chk("t3 F sat low", f_o[0], -512);
        chk("t3 V via E", v_o[0], 509);
        drive(0, 0, 0, 0);
        cyc();
        cyc();

        // Loaded penalties; reload during the last active cycle applies later.
        set_cfg(5, -2, -4, -1);
        cyc();
        cfg_load = 1'b0;
        drive(1, 0, 0, 0);
        cyc();
        chk("t4 V c0", v_o[0], 5);
        cyc();
        chk("t4 V c1", v_o[0], 5);
        set_cfg(2, -2, -2, -1);
        cyc();
        cfg_load = 1'b0;
        chk("t4 V c2 old pen", v_o[0], 5);
        drive(0, 0, 0, 0);
        cyc();
        cyc();
        rd_load = 1'b1;
        cyc();
        rd_load = 1'b0;
        chk("t4 res tie col0", res_o[0], 5 * 65536 + 0);

        // Gap path, then a diagonal improvement at column 1.
        drive(1, 1, 10, 5);
        cyc();
        chk("t5 F_out0", f_o[0], 8);
        chk("t5 V_out0", v_o[0], 8);
        drive(1, 0, 0, 0);
        cyc();
        chk("t5 V col1", v_o[0], 12);
        drive(0, 0, 0, 0);
        cyc();
        cyc();
        rd_load = 1'b1;
        rd_shift = 1'b1;
        cyc();
        chk("t5 load beats shift", res_o[0], 12 * 65536 + 1);
        rd_load = 1'b0;
        cyc();
        cyc();
        rd_shift = 1'b0;
        cyc();

        // Mid-run reset restores defaults and clears outputs at once.
        set_cfg(7, -3, -3, -2);
        cyc();
        cfg_load = 1'b0;
        drive(1, 0, 0, 0);
        cyc();
        chk("t6 V pen7", v_o[0], 7);
        cyc();
        #1 rst = 1'b1;
        #1;
        chk("t6 rst V_out0", v_o[0], 0);
        chk("t6 rst init_out0", init_o[0], 0);
        chk("t6 rst res_out0", res_o[0], 0);
        drive(0, 0, 0, 0);
        cyc();
        rst = 1'b0;
        cyc();
        drive(1, 0, 0, 0);
        cyc();
        chk("t6 default pen", v_o[0], 2);
        drive(0, 0, 0, 0);
        cyc();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
